// File: rtl/random_delay_timer_pkg.sv
// -----------------------------------------------------------------------------
// random_delay_timer_pkg
//
// Shared definitions for the light-game blocks (start-light sequencer,
// random delay timer and their tick sources).
//
// Contents:
//   state_t          - control FSM encoding for the random delay timer.
//                      The encoding is fixed so that a debug probe or checker
//                      can decode the state without the package.
//   DEFAULT_CLK_HZ   - default system clock frequency in Hz.
//   DEFAULT_TICK_HZ  - default delay unit rate in Hz (1 ms units).
//   calc_div()       - prescaler divide ratio for a clock/tick rate pair.
// -----------------------------------------------------------------------------
package random_delay_timer_pkg;

    localparam int DEFAULT_CLK_HZ  = 50_000_000;
    localparam int DEFAULT_TICK_HZ = 1_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_FIRE  = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    // Integer divide ratio between the system clock and the tick rate.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage : random_delay_timer_pkg

// File: rtl/random_delay_timer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Prescaler producing one single-cycle tick every DIV enabled clocks.
// The internal counter runs 0..DIV-1; the tick is asserted during the cycle
// in which the counter holds DIV-1, so the wrap back to 0 and the consumer's
// reaction to the tick happen on the same posedge.
//
// Parameters:
//   DIV   - divide ratio, integer >= 2.
//
// Ports:
//   clk   in  1  system clock, posedge active.
//   rst   in  1  synchronous active-high reset, counter to 0.
//   clear in  1  synchronous clear, counter to 0 (overrides en).
//   en    in  1  count enable.
//   tick  out 1  high for the one cycle that ends with the counter wrapping.
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Decoded from the registered count; a clear in the same cycle cancels
    // the tick so the consumer never sees a tick from a discarded period.
    assign tick = en && !clear && (cnt == LAST);

endmodule : tick_gen

// File: rtl/random_delay_timer.sv
// -----------------------------------------------------------------------------
// random_delay_timer
//
// Waits a randomised number of milliseconds after the start-light sequencer
// raises start, then emits a single-cycle time_out pulse.
//
//   delay D = MIN_MS + (rand_val << RAND_SHIFT)   [ms, CNT_W bits, unsigned]
//
// rand_val is captured only on the cycle start is accepted. Dropping start
// during the count aborts silently; after the pulse the block parks in HOLD
// until start is released, so a start level left high cannot re-trigger.
//
// Handshake: start is a level request. It is accepted on the first posedge
// in IDLE that sees it high, must stay high for the whole count (a low level
// aborts), and must go low once after time_out before the next request is
// accepted. time_out is a one-cycle pulse with no back-pressure.
//
// Parameters:
//   CLK_HZ, TICK_HZ  - clock and delay-unit rates, DIV = CLK_HZ/TICK_HZ >= 2.
//   RAND_W           - width of rand_val.
//   RAND_SHIFT       - left shift applied to rand_val.
//   MIN_MS           - fixed minimum delay.
//   CNT_W            - ms counter width, holds the largest D.
//
// Ports:
//   clk       in  1       system clock, posedge active.
//   rst       in  1       synchronous active-high reset.
//   start     in  1       level request from the sequencer.
//   rand_val  in  RAND_W  random value, sampled on the accepting cycle.
//   time_out  out 1       single-cycle end-of-delay pulse (registered).
//   busy      out 1       high in COUNT and FIRE (registered).
//   ms_left   out CNT_W   remaining ms while counting, else 0 (registered).
//   state     out 2       current FSM state, for debug and checkers.
// -----------------------------------------------------------------------------
module random_delay_timer
    import random_delay_timer_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int TICK_HZ    = DEFAULT_TICK_HZ,
    parameter int RAND_W     = 7,
    parameter int RAND_SHIFT = 4,
    parameter int MIN_MS     = 250,
    parameter int CNT_W      = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RAND_W-1:0] rand_val,
    output logic              time_out,
    output logic              busy,
    output logic [CNT_W-1:0]  ms_left,
    output state_t            state
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    // ------------------------------------------------------------------
    // Delay arithmetic: zero-extend before shifting so no random bits are
    // lost off the top of the RAND_W-wide input.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] rand_ext;
    logic [CNT_W-1:0] delay_ms;

    assign rand_ext = CNT_W'(rand_val);
    assign delay_ms = CNT_W'(MIN_MS) + (rand_ext << RAND_SHIFT);

    // ------------------------------------------------------------------
    // Millisecond prescaler. It only runs while counting with start held;
    // in every other situation it is forced back to 0 so each new count
    // starts a full ms period from the accepting edge.
    // ------------------------------------------------------------------
    logic tick_en;
    logic tick_clear;
    logic ms_tick;

    assign tick_en    = (state == ST_COUNT);
    assign tick_clear = (state != ST_COUNT) || !start;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .en    (tick_en),
        .tick  (ms_tick)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            time_out <= 1'b0;
            busy     <= 1'b0;
            ms_left  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    time_out <= 1'b0;
                    if (start) begin
                        state   <= ST_COUNT;
                        busy    <= 1'b1;
                        ms_left <= delay_ms;
                    end else begin
                        busy    <= 1'b0;
                        ms_left <= '0;
                    end
                end

                ST_COUNT: begin
                    if (!start) begin
                        // Abort wins over a coincident tick: no pulse.
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        ms_left  <= '0;
                        time_out <= 1'b0;
                    end else if (ms_tick) begin
                        // A zero delay (only possible with MIN_MS=0) is
                        // treated like 1 ms rather than wrapping around.
                        if (ms_left <= CNT_W'(1)) begin
                            state    <= ST_FIRE;
                            ms_left  <= '0;
                            time_out <= 1'b1;
                        end else begin
                            ms_left  <= ms_left - 1'b1;
                        end
                    end
                end

                ST_FIRE: begin
                    state    <= ST_HOLD;
                    time_out <= 1'b0;
                    busy     <= 1'b0;
                    ms_left  <= '0;
                end

                ST_HOLD: begin
                    time_out <= 1'b0;
                    busy     <= 1'b0;
                    ms_left  <= '0;
                    if (!start) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    time_out <= 1'b0;
                    busy     <= 1'b0;
                    ms_left  <= '0;
                end
            endcase
        end
    end

endmodule : random_delay_timer
